// File: rtl/dio_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : dio_input_debouncer
// Description : Synchronises and debounces IN_WIDTH raw input pins, emits
//               per-bit edge pulses and a sticky event mask with ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dio_input_debouncer #(
    parameter int IN_WIDTH        = 8,
    parameter int DEBOUNCE_CYCLES = 125000,
    parameter int CNT_WIDTH       = 17
) (
    input  logic                clk_i,
    input  logic                rstn_i,
    input  logic [IN_WIDTH-1:0] pin_i,
    output logic [IN_WIDTH-1:0] val_o,
    output logic [IN_WIDTH-1:0] rise_o,
    output logic [IN_WIDTH-1:0] fall_o,
    output logic                event_valid_o,
    output logic [IN_WIDTH-1:0] event_mask_o,
    input  logic                event_ack_i
);

    localparam logic [0:0]           c_STABLE   = 1'b0;
    localparam logic [0:0]           c_COUNTING = 1'b1;
    localparam logic [CNT_WIDTH-1:0] c_CNT_TERM = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_CNT_ONE  = CNT_WIDTH'(1);

    logic [IN_WIDTH-1:0] r_sync1;
    logic [IN_WIDTH-1:0] r_sync2;
    logic [IN_WIDTH-1:0] r_mask;
    logic                r_valid;
    logic [IN_WIDTH-1:0] w_chg;
    logic [IN_WIDTH-1:0] w_mask_nxt;

    // Two-flop synchroniser; the first stage feeds nothing but the second.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= pin_i;
            r_sync2 <= r_sync1;
        end
    end

    generate
        for (genvar i = 0; i < IN_WIDTH; i++) begin : g_bit
            logic [0:0]           r_state;
            logic [0:0]           w_state_nxt;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic [CNT_WIDTH-1:0] w_cnt_nxt;
            logic                 r_val;
            logic                 w_val_nxt;
            logic                 r_rise;
            logic                 r_fall;
            logic                 w_rise_nxt;
            logic                 w_fall_nxt;
            logic                 w_diff;

            assign w_diff = r_sync2[i] ^ r_val;

            always_ff @(posedge clk_i or negedge rstn_i) begin
                if (!rstn_i) begin
                    r_state <= c_STABLE;
                    r_cnt   <= '0;
                    r_val   <= 1'b0;
                    r_rise  <= 1'b0;
                    r_fall  <= 1'b0;
                end else begin
                    r_state <= w_state_nxt;
                    r_cnt   <= w_cnt_nxt;
                    r_val   <= w_val_nxt;
                    r_rise  <= w_rise_nxt;
                    r_fall  <= w_fall_nxt;
                end
            end

            // Any sample equal to the current level restarts the count from zero.
            always_comb begin
                w_state_nxt = r_state;
                w_cnt_nxt   = r_cnt;
                w_val_nxt   = r_val;
                case (r_state)
                    c_STABLE: begin
                        if (w_diff) begin
                            w_state_nxt = c_COUNTING;
                            w_cnt_nxt   = c_CNT_ONE;
                        end else begin
                            w_cnt_nxt   = '0;
                        end
                    end
                    c_COUNTING: begin
                        if (!w_diff) begin
                            w_state_nxt = c_STABLE;
                            w_cnt_nxt   = '0;
                        end else if (r_cnt == c_CNT_TERM) begin
                            w_state_nxt = c_STABLE;
                            w_cnt_nxt   = '0;
                            w_val_nxt   = r_sync2[i];
                        end else begin
                            w_cnt_nxt   = r_cnt + c_CNT_ONE;
                        end
                    end
                    default: begin
                        w_state_nxt = c_STABLE;
                        w_cnt_nxt   = '0;
                    end
                endcase
            end

            // Pulses are registered alongside the level so they line up with it.
            always_comb begin
                w_rise_nxt = w_val_nxt & ~r_val;
                w_fall_nxt = ~w_val_nxt & r_val;
            end

            assign val_o[i]  = r_val;
            assign rise_o[i] = r_rise;
            assign fall_o[i] = r_fall;
        end
    endgenerate

    // Ack clears the old bits, while changes landing in the same cycle survive.
    assign w_chg      = rise_o | fall_o;
    assign w_mask_nxt = (event_ack_i ? '0 : r_mask) | w_chg;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_mask  <= '0;
            r_valid <= 1'b0;
        end else begin
            r_mask  <= w_mask_nxt;
            r_valid <= |w_mask_nxt;
        end
    end

    assign event_mask_o  = r_mask;
    assign event_valid_o = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_dio_input_debouncer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_dio_input_debouncer
// Description : Directed and random checks of dio_input_debouncer against a
//               sliding-window reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dio_input_debouncer;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [W-1:0] pin = '0;
    logic         ack = 1'b0;
    logic [W-1:0] val, rise, fall, mask;
    logic         valid;

    int checks = 0;
    int errors = 0;
    int n;

    dio_input_debouncer #(
        .IN_WIDTH       (W),
        .DEBOUNCE_CYCLES(D),
        .CNT_WIDTH      (3)
    ) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .pin_i        (pin),
        .val_o        (val),
        .rise_o       (rise),
        .fall_o       (fall),
        .event_valid_o(valid),
        .event_mask_o (mask),
        .event_ack_i  (ack)
    );

    always #5 clk = ~clk;

    // Reference: a level flips once the last D synchronised samples all disagree with it.
    logic [W-1:0] m_p1, m_p2, m_val, m_rise, m_fall, m_mask;
    logic         m_valid;
    logic [W-1:0] m_win [D];
    int           m_fill;

    task automatic model_reset();
        m_p1 = '0; m_p2 = '0; m_val = '0; m_rise = '0; m_fall = '0;
        m_mask = '0; m_valid = 1'b0; m_fill = 0;
        for (int i = 0; i < D; i++) m_win[i] = '0;
    endtask

    task automatic model_step();
        logic [W-1:0] nval;
        logic [W-1:0] nmask;
        bit           all_diff;
        for (int i = D - 1; i > 0; i--) m_win[i] = m_win[i-1];
        m_win[0] = m_p2;
        if (m_fill < D) m_fill++;
        nval = m_val;
        for (int b = 0; b < W; b++) begin
            all_diff = (m_fill >= D);
            for (int i = 0; i < D; i++)
                if (m_win[i][b] == m_val[b]) all_diff = 0;
            if (all_diff) nval[b] = ~m_val[b];
        end
        nmask   = (ack ? '0 : m_mask) | m_rise | m_fall;
        m_mask  = nmask;
        m_valid = |nmask;
        m_rise  = nval & ~m_val;
        m_fall  = ~nval & m_val;
        m_val   = nval;
        m_p2    = m_p1;
        m_p1    = pin;
    endtask

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("val", val, m_val);
        chk("rise", rise, m_rise);
        chk("fall", fall, m_fall);
        chk("mask", mask, m_mask);
        chk("valid", {7'd0, valid}, {7'd0, m_valid});
    endtask

    task automatic tick();
        @(posedge clk);
        if (rstn) model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic ticks(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wait_val(input logic [W-1:0] sel, input logic [W-1:0] lvl, output int cnt);
        cnt = 0;
        while (((val & sel) !== lvl) && cnt < 40) begin
            tick();
            cnt++;
        end
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    initial begin
        model_reset();
        ticks(2);
        chk("reset_val", val, 8'h00);
        chk("reset_valid", {7'd0, valid}, 8'h00);
        rstn = 1'b1;
        ticks(2);

        // 1: single step, latency and event
        pin = 8'h01;
        wait_val(8'h01, 8'h01, n);
        chk("t1_latency", 8'(n), 8'd6);
        chk("t1_rise", rise, 8'h01);
        tick();
        chk("t1_rise_gone", rise, 8'h00);
        chk("t1_mask", mask, 8'h01);
        chk("t1_valid", {7'd0, valid}, 8'h01);
        do_ack();
        pin = 8'h00;
        ticks(10);
        do_ack();
        chk("t1_cleared", {7'd0, valid}, 8'h00);

        // 2: short glitch is rejected
        pin = 8'h01;
        ticks(3);
        pin = 8'h00;
        ticks(10);
        chk("t2_val", val, 8'h00);
        chk("t2_valid", {7'd0, valid}, 8'h00);

        // 3: bounce then hold
        pin = 8'h01; tick();
        pin = 8'h00; tick();
        pin = 8'h01;
        wait_val(8'h01, 8'h01, n);
        chk("t3_latency", 8'(n), 8'd6);
        pin = 8'h00;
        ticks(10);
        do_ack();

        // 4: two bits together, then accumulate a fall
        pin = 8'h81;
        wait_val(8'hFF, 8'h81, n);
        chk("t4_rise", rise, 8'h81);
        pin = 8'h80;
        wait_val(8'h01, 8'h00, n);
        chk("t4_fall", fall, 8'h01);
        tick();
        chk("t4_mask", mask, 8'h81);
        pin = 8'h00;
        ticks(10);
        do_ack();

        // 5: ack coinciding with a new change
        pin = 8'h01;
        ticks(10);
        chk("t5_mask_pre", mask, 8'h01);
        pin = 8'h05;
        wait_val(8'h04, 8'h04, n);
        chk("t5_rise2", rise, 8'h04);
        do_ack();
        chk("t5_mask_after", mask, 8'h04);
        chk("t5_valid_after", {7'd0, valid}, 8'h01);
        do_ack();
        chk("t5_mask_clr", mask, 8'h00);
        chk("t5_valid_clr", {7'd0, valid}, 8'h00);

        // 6: reset while counting
        pin = 8'h07;
        ticks(4);
        rstn = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t6_val_rst", val, 8'h00);
        ticks(2);
        @(negedge clk);
        rstn = 1'b1;
        wait_val(8'hFF, 8'h07, n);
        chk("t6_latency", 8'(n), 8'd6);

        // random phase
        for (int i = 0; i < 900; i++) begin
            for (int b = 0; b < W; b++)
                if ($urandom_range(0, 9) == 0) pin[b] = ~pin[b];
            ack = ($urandom_range(0, 3) == 0);
            if (i == 450) begin
                rstn = 1'b0;
                model_reset();
                #1;
                check_all();
                tick();
                @(negedge clk);
                rstn = 1'b1;
            end
            tick();
        end
        ack = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
